// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and helpers for the sign-magnitude add/sub result path
package alu_pkg;

    localparam int RES_W = 4;
    localparam int MAG_W = 3;

    typedef struct packed {
        logic             op;
        logic [RES_W-1:0] r;
        logic             sf;
        logic             zf;
        logic             dzf;
    } alu_res_t;

    // Negative zero (1000) folds to 0000 because the negated magnitude is zero.
    function automatic logic [RES_W-1:0] sm_to_tc(input logic [RES_W-1:0] sm);
        logic [RES_W-1:0] mag;
        mag = {1'b0, sm[MAG_W-1:0]};
        return sm[RES_W-1] ? (~mag + 1'b1) : mag;
    endfunction

endpackage

// File: rtl/alu_sm2tc.sv
// rtl/alu_sm2tc.sv - combinational 4-bit sign-magnitude to two's-complement converter
module alu_sm2tc
    import alu_pkg::*;
(
    input  logic [RES_W-1:0] sm_i,
    output logic [RES_W-1:0] tc_o
);

    assign tc_o = sm_to_tc(sm_i);

endmodule

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - result FIFO with two's-complement view, zero/negative stats and error flag
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [RES_W-1:0] in_r,
    input  logic             in_sf,
    input  logic             in_zf,
    input  logic             in_dzf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_op,
    output logic [RES_W-1:0] out_r,
    output logic [RES_W-1:0] out_tc,
    output logic             out_sf,
    output logic             out_zf,
    output logic             out_dzf,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [CNT_W-1:0] neg_cnt,
    output logic             err_flag,
    input  logic             clr_stats
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    alu_res_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [CNT_W-1:0] neg_cnt_q, neg_cnt_d;
    logic             err_q, err_d;

    logic     full, empty, push, pop, flag_err;
    alu_res_t in_res, head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = !empty && out_ready;

    assign in_res = '{op: in_op, r: in_r, sf: in_sf, zf: in_zf, dzf: in_dzf};

    assign flag_err = in_dzf
                   || (in_zf != (in_r[MAG_W-1:0] == '0))
                   || (in_sf && in_zf);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        zero_cnt_d = zero_cnt_q;
        neg_cnt_d  = neg_cnt_q;
        err_d      = err_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A clear coinciding with a push drops that push's contribution.
        if (clr_stats) begin
            zero_cnt_d = '0;
            neg_cnt_d  = '0;
            err_d      = 1'b0;
        end else if (push) begin
            zero_cnt_d = sat_inc(zero_cnt_q, in_zf);
            neg_cnt_d  = sat_inc(neg_cnt_q, in_sf);
            err_d      = err_q | flag_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            zero_cnt_q <= '0;
            neg_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            zero_cnt_q <= zero_cnt_d;
            neg_cnt_q  <= neg_cnt_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_res;
    end

    assign head = empty ? '0 : mem_q[rd_ptr_q];

    assign out_op  = head.op;
    assign out_r   = head.r;
    assign out_sf  = head.sf;
    assign out_zf  = head.zf;
    assign out_dzf = head.dzf;

    alu_sm2tc u_sm2tc (
        .sm_i (head.r),
        .tc_o (out_tc)
    );

    assign zero_cnt = zero_cnt_q;
    assign neg_cnt  = neg_cnt_q;
    assign err_flag = err_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - scoreboard bench for alu_result_fifo
module tb_alu_result_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_op = 1'b0, in_sf = 1'b0, in_zf = 1'b0, in_dzf = 1'b0;
    logic [3:0] in_r = 4'b0;
    logic       out_ready = 1'b0, clr_stats = 1'b0;
    logic       in_ready, out_valid, out_op, out_sf, out_zf, out_dzf, err_flag;
    logic [3:0] out_r, out_tc;
    logic [7:0] zero_cnt, neg_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] exp_q [$];
    logic [3:0]  t3_r [8];
    logic [3:0]  t3_tc [8];

    alu_result_fifo #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_r(in_r),
        .in_sf(in_sf), .in_zf(in_zf), .in_dzf(in_dzf),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_r(out_r),
        .out_tc(out_tc), .out_sf(out_sf), .out_zf(out_zf), .out_dzf(out_dzf),
        .zero_cnt(zero_cnt), .neg_cnt(neg_cnt), .err_flag(err_flag), .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Returns at posedge+1 after the accepting edge.
    task automatic push(input logic op, input logic [3:0] r, input logic sf, input logic zf,
                        input logic dzf, input logic [3:0] tc);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1; in_op = op; in_r = r; in_sf = sf; in_zf = zf; in_dzf = dzf;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (acc) exp_q.push_back({op, r, sf, zf, dzf, tc});
        else     check("push_timeout", {31'b0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_left", exp_q.size(), 32'd0);
        check("drain_empty", {31'b0, out_valid}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0)
                        check("spurious_pop", {31'b0, out_valid}, 32'd0);
                    else
                        check("head", {20'b0, out_op, out_r, out_sf, out_zf, out_dzf, out_tc},
                              {20'b0, exp_q.pop_front()});
                end
            end else begin
                check("empty_data", {20'b0, out_op, out_r, out_sf, out_zf, out_dzf, out_tc}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        t3_r  = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0111};
        t3_tc = '{4'b1111, 4'b1110, 4'b1101, 4'b1100, 4'b1011, 4'b1010, 4'b1001, 4'b0111};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_zero_cnt", {24'b0, zero_cnt}, 32'd0);
        check("rst_neg_cnt", {24'b0, neg_cnt}, 32'd0);
        check("rst_err", {31'b0, err_flag}, 32'd0);
        rst = 1'b0;

        // Single push, -5 in sign-magnitude
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_op = 1'b1; in_r = 4'b1101; in_sf = 1'b1; in_zf = 1'b0; in_dzf = 1'b0;
        #1;
        check("no_bypass", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back({1'b1, 4'b1101, 1'b1, 1'b0, 1'b0, 4'b1011});
        check("t1_valid", {31'b0, out_valid}, 32'd1);
        check("t1_r", {28'b0, out_r}, 32'b1101);
        check("t1_tc", {28'b0, out_tc}, 32'b1011);
        check("t1_neg", {24'b0, neg_cnt}, 32'd1);
        push(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0101);
        push(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b1001);
        push(1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 4'b0111);
        drain();
        check("t1_neg2", {24'b0, neg_cnt}, 32'd2);

        // Fill, hold off the fifth, then release
        out_ready = 1'b0;
        push(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001);
        push(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 4'b1110);
        push(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 4'b0011);
        push(1'b1, 4'b1100, 1'b1, 1'b0, 1'b0, 4'b1100);
        check("t2_full", {31'b0, in_ready}, 32'd0);
        fork
            push(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0110);
            begin
                repeat (2) @(posedge clk);
                #1;
                check("t2_held", {31'b0, in_ready}, 32'd0);
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                check("t2_ready_rise", {31'b0, in_ready}, 32'd1);
            end
        join
        drain();
        check("t2_neg", {24'b0, neg_cnt}, 32'd4);

        // Full FIFO streaming with both sides active; exercises pointer wrap
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(1'b0, 4'(i), 1'b0, 1'b0, 1'b0, 4'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(1'b1, t3_r[i], t3_r[i][3], 1'b0, 1'b0, t3_tc[i]);
        drain();
        check("t3_neg", {24'b0, neg_cnt}, 32'd11);

        // Zero results and flag consistency
        push(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
        push(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b0000);
        check("t4_err_clean", {31'b0, err_flag}, 32'd0);
        push(1'b0, 4'b0011, 1'b0, 1'b1, 1'b0, 4'b0011);
        check("t4_err_set", {31'b0, err_flag}, 32'd1);
        check("t4_zero", {24'b0, zero_cnt}, 32'd3);

        // Saturation, then clear racing a push
        for (int i = 0; i < 300; i++) push(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
        check("t5_sat", {24'b0, zero_cnt}, 32'd255);
        check("t5_neg_hold", {24'b0, neg_cnt}, 32'd11);
        clr_stats = 1'b1;
        push(1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 4'b0011);
        clr_stats = 1'b0;
        check("t5_clr_zero", {24'b0, zero_cnt}, 32'd0);
        check("t5_clr_neg", {24'b0, neg_cnt}, 32'd0);
        check("t5_clr_err", {31'b0, err_flag}, 32'd0);
        push(1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010);
        check("t5_dzf_err", {31'b0, err_flag}, 32'd1);
        drain();

        // Asynchronous reset with entries queued
        out_ready = 1'b0;
        push(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001);
        push(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b1010);
        push(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0101);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid", {31'b0, out_valid}, 32'd0);
        check("t6_data", {20'b0, out_op, out_r, out_sf, out_zf, out_dzf, out_tc}, 32'd0);
        check("t6_err", {31'b0, err_flag}, 32'd0);
        check("t6_neg", {24'b0, neg_cnt}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t6_in_ready", {31'b0, in_ready}, 32'd1);
        check("t6_empty", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        push(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 4'b1101);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
